// File: rtl/mult_share_arb_pkg.sv
// Shared constants, output-buffer state encoding and operand slice helper
// for the shared-multiplier arbiter.
package mult_share_arb_pkg;

  localparam int MULT_W  = 16;
  localparam int PROD_W  = 32;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_st_e;

  // Callers zero-extend their packed bus to MAX_REQ slices first.
  function automatic logic [MULT_W-1:0] get_slice(
    input logic [MAX_REQ*MULT_W-1:0] packed_v,
    input logic [31:0]               idx
  );
    return packed_v[idx*MULT_W +: MULT_W];
  endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester operand channel plus tagged response channel of the shared multiplier.
interface mult_share_arb_if
  import mult_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*MULT_W-1:0] req_a;
  logic [N_REQ*MULT_W-1:0] req_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic [PROD_W-1:0]       res_data;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/mult_16_16_top.sv
// Combinational signed 16x16 multiplier: radix-4 Booth partial products
// reduced by a carry-save (Wallace) tree and one final adder.
module mult_16_16_top (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] pp [8];
  logic [16:0] bx;
  logic [31:0] a_ext;

  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  assign bx    = {b, 1'b0};
  assign a_ext = {{16{a[15]}}, a};

  // Each overlapping bit triplet of b selects 0, +-a or +-2a.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      logic [31:0] m;
      m = '0;
      case (bx[2*k +: 3])
        3'b001, 3'b010: m = a_ext;
        3'b011:         m = a_ext << 1;
        3'b100:         m = -(a_ext << 1);
        3'b101, 3'b110: m = -a_ext;
        default:        m = '0;
      endcase
      pp[k] = m << (2 * k);
    end
  end

  logic [31:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  assign {s0, c0} = csa(pp[0], pp[1], pp[2]);
  assign {s1, c1} = csa(pp[3], pp[4], pp[5]);
  assign {s2, c2} = csa(s0, c0, s1);
  assign {s3, c3} = csa(c1, pp[6], pp[7]);
  assign {s4, c4} = csa(s2, c2, s3);
  assign {s5, c5} = csa(s4, c4, c3);
  assign p        = s5 + c5;

endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping mod N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (!found && req[idx]) begin
          found     = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
      if (found) grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// N_REQ requesters share one signed 16x16 multiplier; the product lands in a
// one-deep tagged output buffer that may be refilled in the cycle it drains.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  mult_share_arb_if.slave   bus
);

  localparam int PTR_W = $clog2(N_REQ);

  buf_st_e                  state, state_nxt;
  logic [PTR_W-1:0]         ptr, grant_idx;
  logic [N_REQ-1:0]         grant;
  logic                     can_accept, xfer;
  logic [MAX_REQ*MULT_W-1:0] a_ext, b_ext;
  logic [MULT_W-1:0]        op_a, op_b;
  logic [PROD_W-1:0]        prod;
  logic [ID_W-1:0]          res_id_q;
  logic [PROD_W-1:0]        res_data_q;

  assign can_accept = (state == ST_EMPTY) | (bus.res_ready & (state == ST_FULL));

  // Reset also masks grants so req_ready reads zero while held in reset.
  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .en        (can_accept & sys_rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign xfer          = |(grant & bus.req_valid);

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[N_REQ*MULT_W-1:0] = bus.req_a;
    b_ext[N_REQ*MULT_W-1:0] = bus.req_b;
  end

  assign op_a = (|grant) ? get_slice(a_ext, 32'(grant_idx)) : '0;
  assign op_b = (|grant) ? get_slice(b_ext, 32'(grant_idx)) : '0;

  mult_16_16_top u_mult (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (xfer) state_nxt = ST_FULL;
      ST_FULL: begin
        if (xfer)               state_nxt = ST_FULL;
        else if (bus.res_ready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // On drain without refill the data/tag simply hold their last values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      res_id_q   <= '0;
      res_data_q <= '0;
      ptr        <= '0;
    end else if (xfer) begin
      res_id_q   <= ID_W'(grant_idx);
      res_data_q <= prod;
      if (int'(grant_idx) == N_REQ - 1) ptr <= '0;
      else                              ptr <= grant_idx + 1'b1;
    end
  end

  assign bus.res_valid = (state == ST_FULL);
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Randomized bench for mult_share_arb: a queue-free behavioural model of the
// shared buffer is checked every falling edge, plus hand-computed literal cases.
module tb_mult_share_arb;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mult_share_arb_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  mult_share_arb #(.N_REQ(N), .ID_W(IDW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: buffer contents and round-robin start position.
  bit                 m_full = 1'b0;
  int                 m_id   = 0;
  logic [31:0]        m_data = '0;
  int                 m_ptr  = 0;
  int                 g;
  logic [N-1:0]       exp_rdy;
  logic signed [15:0] sa, sb;
  logic signed [31:0] sp;

  function automatic int model_pick();
    if (m_full && !bus.res_ready) return -1;
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
      chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("rst_res_id",    64'(bus.res_id),    64'(0));
      chk("rst_res_data",  64'(bus.res_data),  64'(0));
      m_full = 1'b0; m_id = 0; m_data = '0; m_ptr = 0;
    end else begin
      g       = model_pick();
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("res_valid", 64'(bus.res_valid), 64'(m_full));
      if (m_full) begin
        chk("res_id",   64'(bus.res_id),   64'(m_id));
        chk("res_data", 64'(bus.res_data), 64'(m_data));
      end
      if (g >= 0) begin
        sa     = bus.req_a[g*16 +: 16];
        sb     = bus.req_b[g*16 +: 16];
        sp     = sa * sb;
        m_full = 1'b1;
        m_id   = g;
        m_data = sp;
        m_ptr  = (g + 1) % N;
      end else if (m_full && bus.res_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*16 +: 16] = rand16();
      bus.req_b[i*16 +: 16] = rand16();
    end
  endtask

  task automatic reset_pulse();
    #2 sys_rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(bus.res_valid), 64'(0));
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;

    // Reset holds req_ready low even with every requester valid.
    #12;
    chk("reset_ready_lit", 64'(bus.req_ready), 64'(0));
    chk("reset_valid_lit", 64'(bus.res_valid), 64'(0));
    @(posedge sys_clk);
    #1 bus.req_valid = '0;
    sys_rst_n = 1'b1;

    // Single request from requester 0.
    bus.req_valid          = 4'b0001;
    bus.req_a[15:0]        = 16'h3524;
    bus.req_b[15:0]        = 16'h5e81;
    #1 chk("single_ready", 64'(bus.req_ready), 64'(4'b0001));
    step();
    bus.req_valid = '0;
    chk("single_valid", 64'(bus.res_valid), 64'(1));
    chk("single_id",    64'(bus.res_id),    64'(0));
    chk("single_data",  64'(bus.res_data),  64'h139DFF24);
    step();
    chk("single_drain", 64'(bus.res_valid), 64'(0));

    // Signed edge cases back to back from requester 2.
    bus.req_valid      = 4'b0100;
    bus.req_a[47:32]   = 16'hFFFF;
    bus.req_b[47:32]   = 16'h0002;
    step();
    bus.req_a[47:32]   = 16'h8000;
    bus.req_b[47:32]   = 16'h8000;
    chk("neg_data", 64'(bus.res_data), 64'hFFFFFFFE);
    chk("neg_id",   64'(bus.res_id),   64'(2));
    step();
    bus.req_valid = '0;
    chk("min_valid", 64'(bus.res_valid), 64'(1));
    chk("min_data",  64'(bus.res_data),  64'h40000000);
    chk("min_id",    64'(bus.res_id),    64'(2));
    step();

    // Fairness: all valid from a fresh pointer.
    reset_pulse();
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      #1 chk("rr_ready", 64'(bus.req_ready), 64'(1 << (k % N)));
      step();
      chk("rr_id",    64'(bus.res_id),    64'(k % N));
      chk("rr_valid", 64'(bus.res_valid), 64'(1));
    end

    // Backpressure with requester 3's product pending.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step();
      chk("bp_ready", 64'(bus.req_ready), 64'(0));
      chk("bp_id",    64'(bus.res_id),    64'(3));
      chk("bp_valid", 64'(bus.res_valid), 64'(1));
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(bus.req_ready), 64'(4'b0001));
    step();
    chk("bp_release_id", 64'(bus.res_id), 64'(0));

    // Skipping idle requesters once the pointer sits at 2.
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b1010;
    #1 chk("skip_ready0", 64'(bus.req_ready), 64'(4'b1000));
    step();
    chk("skip_id0", 64'(bus.res_id), 64'(3));
    chk("skip_ready1", 64'(bus.req_ready), 64'(4'b0010));
    step();
    chk("skip_id1", 64'(bus.res_id), 64'(1));
    step();
    chk("skip_id2", 64'(bus.res_id), 64'(3));

    // Reset between edges while full.
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    step();
    reset_pulse();
    chk("post_rst_data", 64'(bus.res_data), 64'(0));
    bus.req_valid = 4'b1100;
    bus.res_ready = 1'b1;
    #1 chk("post_rst_ready", 64'(bus.req_ready), 64'(4'b0100));
    step();
    chk("post_rst_id", 64'(bus.res_id), 64'(2));

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      bus.req_valid = N'($urandom);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end

    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
